// File: rtl/subleq_run_ctrl.sv
// ---------------------------------------------------------------------------
// subleq_run_ctrl
//
// Run / single-step / breakpoint sequencer for the subleq32 core. It owns the
// core clock-enable, so the core only advances on cycles where oEnable is
// high. It watches the core IP and phase counter to find instruction
// boundaries (phase 0), retirements (phase LAST_PHASE), IP breakpoints and
// the subleq "jump to self" halt idiom.
//
// Ports
//   iClock       system clock, shared with cpu32
//   iReset       asynchronous reset, active-high
//   iRunCmd      pulse: start free-running
//   iStepCmd     pulse: execute exactly one instruction
//   iStopCmd     pulse: stop at the next instruction boundary
//   iBreakEn     breakpoint enable (level)
//   iBreakAddr   breakpoint instruction address
//   iIP          core instruction pointer
//   iPhase       core phase counter
//   oEnable      core clock-enable (combinational)
//   oState       0 IDLE, 1 RUN, 2 STEP, 3 BREAK, 4 HALT
//   oInstrCount  retired instructions, saturating
//   oCycleCount  cycles with oEnable high, saturating
//
// state  | meaning
// -------+-----------------------------------------------------------------
// IDLE   | core stopped, waiting for run / step
// RUN    | core free-running
// STEP   | core executing a single instruction, back to IDLE on retire
// BREAK  | stopped at phase 0 of the breakpoint instruction
// HALT   | self-jump detected; sticky until reset
// ---------------------------------------------------------------------------
module subleq_run_ctrl #(
    parameter int IP_W       = 32,
    parameter int PH_W       = 3,
    parameter int LAST_PHASE = 4
) (
    input  logic            iClock,
    input  logic            iReset,
    input  logic            iRunCmd,
    input  logic            iStepCmd,
    input  logic            iStopCmd,
    input  logic            iBreakEn,
    input  logic [IP_W-1:0] iBreakAddr,
    input  logic [IP_W-1:0] iIP,
    input  logic [PH_W-1:0] iPhase,
    output logic            oEnable,
    output logic [2:0]      oState,
    output logic [31:0]     oInstrCount,
    output logic [31:0]     oCycleCount
);

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_RUN   = 3'd1;
    localparam logic [2:0] S_STEP  = 3'd2;
    localparam logic [2:0] S_BREAK = 3'd3;
    localparam logic [2:0] S_HALT  = 3'd4;

    localparam logic [PH_W-1:0] LAST_PH = PH_W'(LAST_PHASE);

    logic [2:0]      state_q,     state_d;
    logic            stop_pend_q, stop_pend_d;
    logic            skip_bp_q,   skip_bp_d;
    logic [IP_W-1:0] last_ip_q,   last_ip_d;
    logic            have_last_q, have_last_d;
    logic [31:0]     instr_cnt_q, instr_cnt_d;
    logic [31:0]     cycle_cnt_q, cycle_cnt_d;

    logic phase0;
    logic bp_hit;
    logic loop_hit;
    logic active;
    logic stop_req;
    logic stop_now;
    logic retire;

    // ------------------------------------------------------------------
    // Boundary detection and clock-enable
    // ------------------------------------------------------------------
    assign phase0   = (iPhase == '0);
    assign bp_hit   = iBreakEn & phase0 & (iIP == iBreakAddr) & ~skip_bp_q;
    assign loop_hit = have_last_q & phase0 & (iIP == last_ip_q);
    assign active   = (state_q == S_RUN) | (state_q == S_STEP);
    assign stop_req = iStopCmd | stop_pend_q;

    // A stop seen while sitting on phase 0 means no instruction has started
    // yet, so the enable is withheld and the core never leaves the boundary.
    assign stop_now = active & stop_req & phase0;

    assign oEnable  = active & ~bp_hit & ~loop_hit & ~stop_now;
    assign retire   = oEnable & (iPhase == LAST_PH);

    // ------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        state_d     = state_q;
        stop_pend_d = stop_pend_q;
        skip_bp_d   = skip_bp_q;

        if (retire) begin
            skip_bp_d = 1'b0;
        end

        case (state_q)
            S_IDLE, S_BREAK: begin
                // Stop beats step beats run. Resuming sets skip_bp so the
                // instruction parked on the breakpoint can actually execute.
                if (iStopCmd) begin
                    state_d = S_IDLE;
                end else if (iStepCmd) begin
                    state_d   = S_STEP;
                    skip_bp_d = 1'b1;
                end else if (iRunCmd) begin
                    state_d   = S_RUN;
                    skip_bp_d = 1'b1;
                end
            end

            S_RUN: begin
                if (bp_hit) begin
                    state_d = S_BREAK;
                end else if (loop_hit) begin
                    state_d = S_HALT;
                end else if (stop_req && (retire || phase0)) begin
                    // A retiring instruction still counts; the stop lands
                    // on the boundary right after it.
                    state_d = S_IDLE;
                end else if (iStopCmd) begin
                    stop_pend_d = 1'b1;
                end
            end

            S_STEP: begin
                if (bp_hit) begin
                    state_d = S_BREAK;
                end else if (loop_hit) begin
                    state_d = S_HALT;
                end else if (retire) begin
                    state_d = S_IDLE;
                end else if (stop_req && phase0) begin
                    state_d = S_IDLE;
                end else if (iStopCmd) begin
                    stop_pend_d = 1'b1;
                end
            end

            S_HALT: begin
                state_d = S_HALT;
            end

            default: begin
                state_d = S_IDLE;
            end
        endcase

        if ((state_d == S_IDLE) || (state_d == S_BREAK) || (state_d == S_HALT)) begin
            stop_pend_d = 1'b0;
        end
    end

    // ------------------------------------------------------------------
    // Loop tracker and counters
    // ------------------------------------------------------------------
    always_comb begin
        last_ip_d   = last_ip_q;
        have_last_d = have_last_q;
        instr_cnt_d = instr_cnt_q;
        cycle_cnt_d = cycle_cnt_q;

        // Remember the IP of each instruction as it starts; seeing the same
        // IP at the next boundary means the core jumped to itself.
        if (oEnable && phase0) begin
            last_ip_d   = iIP;
            have_last_d = 1'b1;
        end

        if (retire && (instr_cnt_q != 32'hFFFF_FFFF)) begin
            instr_cnt_d = instr_cnt_q + 32'd1;
        end

        if (oEnable && (cycle_cnt_q != 32'hFFFF_FFFF)) begin
            cycle_cnt_d = cycle_cnt_q + 32'd1;
        end
    end

    // ------------------------------------------------------------------
    // Registers
    // ------------------------------------------------------------------
    always_ff @(posedge iClock or posedge iReset) begin
        if (iReset) begin
            state_q     <= S_IDLE;
            stop_pend_q <= 1'b0;
            skip_bp_q   <= 1'b0;
            last_ip_q   <= '0;
            have_last_q <= 1'b0;
            instr_cnt_q <= '0;
            cycle_cnt_q <= '0;
        end else begin
            state_q     <= state_d;
            stop_pend_q <= stop_pend_d;
            skip_bp_q   <= skip_bp_d;
            last_ip_q   <= last_ip_d;
            have_last_q <= have_last_d;
            instr_cnt_q <= instr_cnt_d;
            cycle_cnt_q <= cycle_cnt_d;
        end
    end

    assign oState      = state_q;
    assign oInstrCount = instr_cnt_q;
    assign oCycleCount = cycle_cnt_q;

endmodule

// File: tb/tb_subleq_run_ctrl.sv
module tb_subleq_run_ctrl;

    logic        iClock;
    logic        iReset;
    logic        iRunCmd;
    logic        iStepCmd;
    logic        iStopCmd;
    logic        iBreakEn;
    logic [31:0] iBreakAddr;
    logic [31:0] iIP;
    logic [2:0]  iPhase;
    logic        oEnable;
    logic [2:0]  oState;
    logic [31:0] oInstrCount;
    logic [31:0] oCycleCount;

    int          total;
    int          bad;
    int          en_count;
    logic        last_en;
    logic [31:0] ip_inc;

    subleq_run_ctrl #(
        .IP_W      (32),
        .PH_W      (3),
        .LAST_PHASE(4)
    ) dut (
        .iClock     (iClock),
        .iReset     (iReset),
        .iRunCmd    (iRunCmd),
        .iStepCmd   (iStepCmd),
        .iStopCmd   (iStopCmd),
        .iBreakEn   (iBreakEn),
        .iBreakAddr (iBreakAddr),
        .iIP        (iIP),
        .iPhase     (iPhase),
        .oEnable    (oEnable),
        .oState     (oState),
        .oInstrCount(oInstrCount),
        .oCycleCount(oCycleCount)
    );

    initial iClock = 1'b0;
    always #5 iClock = ~iClock;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp)
        else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // One clock of a stand-in core: the phase advances 0..4 only when the
    // enable was high across the edge, and the IP moves on after phase 4.
    // Command pulses are dropped right after the edge they were sampled on.
    task automatic tick();
        @(negedge iClock);
        last_en = oEnable;
        if (oEnable) en_count++;
        @(posedge iClock);
        #1;
        iRunCmd  = 1'b0;
        iStepCmd = 1'b0;
        iStopCmd = 1'b0;
        if (last_en) begin
            if (iPhase == 3'd4) begin
                iPhase = 3'd0;
                iIP    = iIP + ip_inc;
            end else begin
                iPhase = iPhase + 3'd1;
            end
        end
        #1;
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic do_reset(input logic [31:0] ip, input logic [31:0] inc);
        iReset = 1'b1;
        #1;
        @(posedge iClock);
        #2;
        iReset   = 1'b0;
        iIP      = ip;
        iPhase   = 3'd0;
        ip_inc   = inc;
        en_count = 0;
        #1;
    endtask

    initial begin
        total      = 0;
        bad        = 0;
        en_count   = 0;
        last_en    = 1'b0;
        ip_inc     = 32'd3;
        iReset     = 1'b1;
        iRunCmd    = 1'b0;
        iStepCmd   = 1'b0;
        iStopCmd   = 1'b0;
        iBreakEn   = 1'b0;
        iBreakAddr = 32'd0;
        iIP        = 32'd0;
        iPhase     = 3'd0;

        // Reset state
        #12;
        check("rst_state", 32'(oState), 32'd0);
        check("rst_en",    32'(oEnable), 32'd0);
        check("rst_instr", oInstrCount, 32'd0);
        check("rst_cycle", oCycleCount, 32'd0);

        // Free run over IP 0,3,6,9
        do_reset(32'd0, 32'd3);
        iRunCmd = 1'b1;
        tick();
        check("run_state", 32'(oState), 32'd1);
        en_count = 0;
        ticks(20);
        check("run_en_cycles", 32'(en_count), 32'd20);
        check("run_instr", oInstrCount, 32'd4);
        check("run_cycle", oCycleCount, 32'd20);
        check("run_state2", 32'(oState), 32'd1);
        check("run_ip", iIP, 32'h0C);

        // Single step at 0x10
        do_reset(32'h10, 32'd3);
        iStepCmd = 1'b1;
        tick();
        check("step_state", 32'(oState), 32'd2);
        en_count = 0;
        ticks(8);
        check("step_en_cycles", 32'(en_count), 32'd5);
        check("step_instr", oInstrCount, 32'd1);
        check("step_state_idle", 32'(oState), 32'd0);
        check("step_en_off", 32'(oEnable), 32'd0);
        check("step_ip", iIP, 32'h13);
        check("step_phase", 32'(iPhase), 32'd0);

        // Breakpoint at 0x0C, then step over it
        do_reset(32'd0, 32'd3);
        iBreakEn   = 1'b1;
        iBreakAddr = 32'h0C;
        iRunCmd    = 1'b1;
        tick();
        ticks(20);
        check("bp_ip", iIP, 32'h0C);
        check("bp_en_drop", 32'(oEnable), 32'd0);
        tick();
        check("bp_state", 32'(oState), 32'd3);
        check("bp_instr", oInstrCount, 32'd4);
        check("bp_hold_ip", iIP, 32'h0C);
        iStepCmd = 1'b1;
        tick();
        check("bp_step_state", 32'(oState), 32'd2);
        check("bp_step_en", 32'(oEnable), 32'd1);
        ticks(5);
        check("bp_step_instr", oInstrCount, 32'd5);
        check("bp_step_idle", 32'(oState), 32'd0);
        check("bp_step_ip", iIP, 32'h0F);
        iBreakEn = 1'b0;

        // Self-jump at 0x20 halts after one retire
        do_reset(32'h20, 32'd0);
        iRunCmd = 1'b1;
        tick();
        ticks(5);
        check("loop_instr", oInstrCount, 32'd1);
        check("loop_en_drop", 32'(oEnable), 32'd0);
        tick();
        check("loop_state", 32'(oState), 32'd4);
        iRunCmd = 1'b1;
        tick();
        ticks(3);
        check("loop_sticky", 32'(oState), 32'd4);
        check("loop_sticky_en", 32'(oEnable), 32'd0);
        check("loop_cycle", oCycleCount, 32'd5);
        do_reset(32'h20, 32'd0);
        check("loop_rst_state", 32'(oState), 32'd0);
        check("loop_rst_instr", oInstrCount, 32'd0);
        check("loop_rst_cycle", oCycleCount, 32'd0);

        // Stop at phase 2 waits for the retire
        do_reset(32'd0, 32'd3);
        iRunCmd = 1'b1;
        tick();
        ticks(2);
        check("stop_phase2", 32'(iPhase), 32'd2);
        iStopCmd = 1'b1;
        tick();
        check("stop_en_p3", 32'(oEnable), 32'd1);
        check("stop_state_p3", 32'(oState), 32'd1);
        tick();
        check("stop_en_p4", 32'(oEnable), 32'd1);
        tick();
        check("stop_state_idle", 32'(oState), 32'd0);
        check("stop_instr", oInstrCount, 32'd1);
        check("stop_en_off", 32'(oEnable), 32'd0);
        check("stop_cycle", oCycleCount, 32'd5);
        iStopCmd = 1'b1;
        iRunCmd  = 1'b1;
        tick();
        ticks(2);
        check("stop_run_same", 32'(oState), 32'd0);
        check("stop_run_cycle", oCycleCount, 32'd5);

        // Asynchronous reset mid-instruction
        do_reset(32'd0, 32'd3);
        iRunCmd = 1'b1;
        tick();
        ticks(3);
        check("arst_phase", 32'(iPhase), 32'd3);
        check("arst_pre_en", 32'(oEnable), 32'd1);
        iReset = 1'b1;
        #1;
        check("arst_en", 32'(oEnable), 32'd0);
        check("arst_state", 32'(oState), 32'd0);
        check("arst_instr", oInstrCount, 32'd0);
        check("arst_cycle", oCycleCount, 32'd0);
        do_reset(32'd0, 32'd3);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
